axi_write_arbiter: RTL and testbench

Shares one boundary-write channel (the downstream port feeding the 4 KB-boundary write stage toward the AXI master) between NUM_REQ write requesters. Grants are burst-locked: a requester keeps the channel for exactly s_len+1 accepted beats, then the channel is re-arbitrated. Arbitration is round-robin by default and selectable as fixed priority at compile time. Beat transfer is a zero-latency combinational pass-through of the granted requester.

---
 rtl/axi_write_arbiter_pkg.sv | 16 +
 rtl/axi_write_arbiter_if.sv | 37 +++
 rtl/axi_arb_rr_pick.sv | 25 ++
 rtl/axi_write_arbiter.sv | 124 ++++++++++++
 tb/tb_axi_write_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_write_arbiter_pkg.sv
// Shared types and helpers for the burst-locked write-channel arbiter.
package axi_write_arbiter_pkg;

   localparam int unsigned LEN_W = 8;

   typedef enum logic [0:0] {
      StIdle,
      StBurst
   } arb_state_e;

   // Grant index width, never narrower than one bit.
   function automatic int unsigned grant_w(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi_write_arbiter_if.sv
// Requester-side and downstream-side signals of the write arbiter in one bundle.
interface axi_write_arbiter_if
   import axi_write_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
);
   localparam int unsigned GRANT_W = grant_w(NUM_REQ);
   localparam int unsigned STRB_W  = DATA_W / 8;

   logic [NUM_REQ-1:0]        s_valid;
   logic [NUM_REQ-1:0]        s_ready;
   logic [NUM_REQ*ADDR_W-1:0] s_addr;
   logic [NUM_REQ*DATA_W-1:0] s_wdata;
   logic [NUM_REQ*STRB_W-1:0] s_wstrb;
   logic [NUM_REQ*LEN_W-1:0]  s_len;
   logic                      m_valid;
   logic                      m_ready;
   logic [ADDR_W-1:0]         m_addr;
   logic [DATA_W-1:0]         m_wdata;
   logic [STRB_W-1:0]         m_wstrb;
   logic [LEN_W-1:0]          m_len;
   logic [GRANT_W-1:0]        m_grant;
   logic                      m_busy;

   modport slave (
      input  s_valid, s_addr, s_wdata, s_wstrb, s_len, m_ready,
      output s_ready, m_valid, m_addr, m_wdata, m_wstrb, m_len, m_grant, m_busy
   );

   modport master (
      output s_valid, s_addr, s_wdata, s_wstrb, s_len, m_ready,
      input  s_ready, m_valid, m_addr, m_wdata, m_wstrb, m_len, m_grant, m_busy
   );

endinterface

// File: rtl/axi_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module axi_arb_rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned GRANT_W = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GRANT_W-1:0] ptr,
   output logic [GRANT_W-1:0] winner,
   output logic               found
);

   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         int unsigned idx;
         idx = (32'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = GRANT_W'(idx);
         end
      end
   end

endmodule

// File: rtl/axi_write_arbiter.sv
// Burst-locked arbiter sharing one boundary-write channel among NUM_REQ requesters.
// Define AXI_WRITE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module axi_write_arbiter
   import axi_write_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
) (
   input logic               clk,
   input logic               rst,
   axi_write_arbiter_if.slave bus
);
   localparam int unsigned GRANT_W = grant_w(NUM_REQ);
   localparam int unsigned STRB_W  = DATA_W / 8;

   arb_state_e         state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d, len_q, len_d;
   logic [GRANT_W-1:0] grant_q, grant_d, ptr, winner;
   logic               found, beat, last;

   logic [NUM_REQ-1:0] s_ready;
   logic               m_valid;
   logic [ADDR_W-1:0]  m_addr;
   logic [DATA_W-1:0]  m_wdata;
   logic [STRB_W-1:0]  m_wstrb;

`ifdef AXI_WRITE_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   logic [GRANT_W-1:0] ptr_q, ptr_d;

   assign ptr = ptr_q;

   // Pointer moves past the requester that just finished its burst.
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == StBurst && beat && last) begin
         ptr_d = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end
`endif

   axi_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .GRANT_W (GRANT_W)
   ) u_pick (
      .req    (bus.s_valid),
      .ptr    (ptr),
      .winner (winner),
      .found  (found)
   );

   always_comb begin
      s_ready = '0;
      m_valid = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_wstrb = '0;
      if (state_q == StBurst) begin
         m_valid          = bus.s_valid[grant_q];
         s_ready[grant_q] = bus.m_ready;
         m_addr           = bus.s_addr[ADDR_W*grant_q +: ADDR_W];
         m_wdata          = bus.s_wdata[DATA_W*grant_q +: DATA_W];
         m_wstrb          = bus.s_wstrb[STRB_W*grant_q +: STRB_W];
      end
   end

   assign beat = m_valid && bus.m_ready;
   assign last = (cnt_q == len_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      grant_d = grant_q;
      case (state_q)
         StIdle: begin
            if (found) begin
               grant_d = winner;
               len_d   = bus.s_len[LEN_W*winner +: LEN_W];
               cnt_d   = '0;
               state_d = StBurst;
            end
         end
         StBurst: begin
            if (beat) begin
               if (last) state_d = StIdle;
               else      cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         len_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         grant_q <= grant_d;
      end
   end

   assign bus.s_ready = s_ready;
   assign bus.m_valid = m_valid;
   assign bus.m_addr  = m_addr;
   assign bus.m_wdata = m_wdata;
   assign bus.m_wstrb = m_wstrb;
   assign bus.m_len   = len_q;
   assign bus.m_grant = grant_q;
   assign bus.m_busy  = (state_q == StBurst);

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: behavioural burst model plus directed scenarios.
module tb_axi_write_arbiter;
   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic clk;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   axi_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   axi_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: owner of the channel (-1 when free), beats still owed, beats taken.
   int own    = -1;
   int mlen   = 0;
   int left   = 0;
   int nbeats = 0;
   int rr     = 0;
   int q_own[$];
   int q_beats[$];
   int q_len[$];

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin : model
      int w;
      if (!rst) begin
         own <= -1; mlen <= 0; left <= 0; nbeats <= 0; rr <= 0;
      end else if (own < 0) begin
`ifdef AXI_WRITE_ARB_FIXED_PRIO_EN
         w = pick(bus.s_valid, 0);
`else
         w = pick(bus.s_valid, rr);
`endif
         if (w >= 0) begin
            own    <= w;
            mlen   <= int'(bus.s_len[8*w +: 8]);
            left   <= int'(bus.s_len[8*w +: 8]) + 1;
            nbeats <= 0;
         end
      end else if (bus.s_valid[own] && bus.m_ready) begin
         nbeats <= nbeats + 1;
         left   <= left - 1;
         if (left == 1) begin
            q_own.push_back(own);
            q_beats.push_back(nbeats + 1);
            q_len.push_back(mlen);
            own <= -1;
            rr  <= (own + 1) % N;
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [N-1:0] er;
      if (!rst) begin
         chk("rst_busy", bus.m_busy, 0);
         chk("rst_valid", bus.m_valid, 0);
         chk("rst_ready", bus.s_ready, 0);
         chk("rst_len", bus.m_len, 0);
         chk("rst_grant", bus.m_grant, 0);
      end else if (own < 0) begin
         chk("idle_busy", bus.m_busy, 0);
         chk("idle_valid", bus.m_valid, 0);
         chk("idle_ready", bus.s_ready, 0);
         chk("idle_addr", bus.m_addr, 0);
         chk("idle_wdata", bus.m_wdata, 0);
         chk("idle_wstrb", bus.m_wstrb, 0);
      end else begin
         er = '0;
         if (bus.m_ready) er[own] = 1'b1;
         chk("busy", bus.m_busy, 1);
         chk("grant", bus.m_grant, own);
         chk("m_len", bus.m_len, mlen);
         chk("m_valid", bus.m_valid, bus.s_valid[own]);
         chk("s_ready", bus.s_ready, er);
         chk("m_addr", bus.m_addr, bus.s_addr[AW*own +: AW]);
         chk("m_wdata", bus.m_wdata, bus.s_wdata[DW*own +: DW]);
         chk("m_wstrb", bus.m_wstrb, bus.s_wstrb[SW*own +: SW]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         bus.s_addr[AW*i +: AW]  = {8'(i + 1), 24'(cyc)};
         bus.s_wdata[DW*i +: DW] = 32'(cyc * 7 + i * 1000);
         bus.s_wstrb[SW*i +: SW] = 4'(cyc + i);
      end
   endtask

   task automatic run_bursts(input string name, input int target, input int bound);
      for (int i = 0; i < bound && q_beats.size() < target; i++) tick();
      chk(name, q_beats.size() >= target, 1);
   endtask

   initial begin
      int base;
      rst         = 1'b0;
      bus.s_valid = '0;
      bus.s_len   = '0;
      bus.s_addr  = '0;
      bus.s_wdata = '0;
      bus.s_wstrb = '0;
      bus.m_ready = 1'b0;
      repeat (3) tick();
      chk("init_busy", bus.m_busy, 0);
      rst = 1'b1;
      tick();

      // Single requester, 4-beat burst, then a free cycle.
      base = q_beats.size();
      bus.m_ready = 1'b1;
      bus.s_len   = {8'd0, 8'd3};
      bus.s_valid = 2'b01;
      run_bursts("t1_timeout", base + 1, 20);
      bus.s_valid = '0;
      if (q_beats.size() > base) begin
         chk("t1_beats", q_beats[base], 4);
         chk("t1_len", q_len[base], 3);
         chk("t1_own", q_own[base], 0);
      end
      chk("t1_idle_busy", bus.m_busy, 0);
      tick();

      // Both requesting single-beat bursts, pointer starting from reset.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      base = q_beats.size();
      bus.s_len   = '0;
      bus.s_valid = 2'b11;
      run_bursts("t2_timeout", base + 4, 40);
      bus.s_valid = '0;
      if (q_own.size() >= base + 4) begin
`ifdef AXI_WRITE_ARB_FIXED_PRIO_EN
         chk("t2_g0", q_own[base], 0);
         chk("t2_g1", q_own[base + 1], 0);
         chk("t2_g2", q_own[base + 2], 0);
         chk("t2_g3", q_own[base + 3], 0);
`else
         chk("t2_g0", q_own[base], 0);
         chk("t2_g1", q_own[base + 1], 1);
         chk("t2_g2", q_own[base + 2], 0);
         chk("t2_g3", q_own[base + 3], 1);
`endif
         chk("t2_beats", q_beats[base + 3], 1);
      end
      tick();

      // Requester 1 with stalls and a valid gap; requester 0 waits.
      base = q_beats.size();
      bus.s_len   = {8'd7, 8'd0};
      bus.s_valid = 2'b10;
      bus.m_ready = 1'b1;
      tick();
      bus.s_valid = 2'b11;
      for (int i = 0; i < 80 && q_beats.size() == base; i++) begin
         bus.m_ready    = ~i[0];
         bus.s_valid[1] = !(i == 2 || i == 3);
         tick();
      end
      bus.s_valid = '0;
      bus.m_ready = 1'b1;
      chk("t3_timeout", q_beats.size() > base, 1);
      if (q_beats.size() > base) begin
         chk("t3_beats", q_beats[base], 8);
         chk("t3_own", q_own[base], 1);
      end
      tick();

      // Maximum length burst.
      base = q_beats.size();
      bus.s_len   = {8'd0, 8'd255};
      bus.s_valid = 2'b01;
      run_bursts("t4_timeout", base + 1, 400);
      bus.s_valid = '0;
      if (q_beats.size() > base) begin
         chk("t4_beats", q_beats[base], 256);
         chk("t4_len", q_len[base], 255);
      end
      tick();

      // Reset after beat 2 of a 5-beat burst.
      bus.s_len   = {8'd0, 8'd4};
      bus.s_valid = 2'b01;
      for (int i = 0; i < 20 && !(own == 0 && nbeats == 2); i++) tick();
      chk("t5_reach", (own == 0 && nbeats == 2), 1);
      rst = 1'b0;
      #1;
      chk("t5_busy", bus.m_busy, 0);
      chk("t5_valid", bus.m_valid, 0);
      chk("t5_ready", bus.s_ready, 0);
      chk("t5_len", bus.m_len, 0);
      tick();
      rst  = 1'b1;
      base = q_beats.size();
      run_bursts("t5_timeout", base + 1, 20);
      bus.s_valid = '0;
      if (q_beats.size() > base) chk("t5_beats", q_beats[base], 5);
      tick();

      // Length change after grant is ignored.
      base = q_beats.size();
      bus.s_len   = {8'd0, 8'd2};
      bus.s_valid = 2'b01;
      for (int i = 0; i < 20 && !(own == 0 && nbeats == 1); i++) tick();
      bus.s_len = {8'd0, 8'd9};
      run_bursts("t6_timeout", base + 1, 20);
      bus.s_valid = '0;
      if (q_beats.size() > base) begin
         chk("t6_beats", q_beats[base], 3);
         chk("t6_len", q_len[base], 2);
      end
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
